// File: rtl/uart_tx_arbiter.sv
// Packet-level two-requester arbiter in front of a single UART transmitter.
// Holds the grant for a whole packet, sequences start/busy, and inserts an idle gap.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT   = 10417,
  parameter int unsigned GAP_BITS       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       abort,
  output logic       busy
);

  localparam int unsigned GapCycles = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GapW      = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam int unsigned ToutW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GapLastI  = (GapCycles == 0) ? 0 : GapCycles - 1;
  localparam int unsigned ToutLastI = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [GapW-1:0]  GapLast  = GapW'(GapLastI);
  localparam logic [ToutW-1:0] ToutLast = ToutW'(ToutLastI);

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StStart,
    StWaitBusy,
    StWaitDone,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             last_q, last_d;
  logic             rr_q, rr_d;  // 1: requester 1 preferred on a tie
  logic             abort_q, abort_d;
  logic [ToutW-1:0] tout_q, tout_d;
  logic [GapW-1:0]  gap_q, gap_d;

  logic       acc_valid;
  logic [7:0] acc_data;
  logic       acc_last;

  always_comb begin
    acc_valid = grant_q[0] ? req0_valid : req1_valid;
    acc_data  = grant_q[0] ? req0_data  : req1_data;
    acc_last  = grant_q[0] ? req0_last  : req1_last;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    rr_d      = rr_q;
    abort_d   = 1'b0;
    tout_d    = tout_q;
    gap_d     = gap_q;

    unique case (state_q)
      StIdle: begin
        if (req0_valid && (!req1_valid || !rr_q)) begin
          grant_d = 2'b01;
          tout_d  = '0;
          state_d = StAccept;
        end else if (req1_valid) begin
          grant_d = 2'b10;
          tout_d  = '0;
          state_d = StAccept;
        end
      end
      StAccept: begin
        if (acc_valid) begin
          tx_data_d = acc_data;
          last_d    = acc_last;
          state_d   = StStart;
        end else if (tout_q == ToutLast) begin
          // Owner stalled mid-packet: revoke and hand preference to the other side.
          abort_d = 1'b1;
          grant_d = 2'b00;
          rr_d    = grant_q[0];
          state_d = StIdle;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      StStart: begin
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (!last_q) begin
            tout_d  = '0;
            state_d = StAccept;
          end else begin
            grant_d = 2'b00;
            rr_d    = grant_q[0];
            if (GAP_BITS != 0) begin
              gap_d   = '0;
              state_d = StGap;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      tx_data_q <= 8'h00;
      last_q    <= 1'b0;
      rr_q      <= 1'b0;
      abort_q   <= 1'b0;
      tout_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      rr_q      <= rr_d;
      abort_q   <= abort_d;
      tout_q    <= tout_d;
      gap_q     <= gap_d;
    end
  end

  assign req0_ready = (state_q == StAccept) && grant_q[0];
  assign req1_ready = (state_q == StAccept) && grant_q[1];
  assign tx_start   = (state_q == StStart);
  assign tx_data    = tx_data_q;
  assign grant      = grant_q;
  assign abort      = abort_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: cycle table for reset/first packet/gap, then hand sequences for
// round-robin, timeout and zero-gap back-to-back grants.
module tb_uart_tx_arbiter;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Busy  = 10 * Cpb;
  localparam int unsigned GapA  = 2 * Cpb;
  localparam int unsigned Tout  = 50;

  logic clk;
  logic rst_n;

  // DUT A: GAP_BITS=2
  logic       v0, l0, v1, l1;
  logic [7:0] d0, d1;
  logic       a_r0, a_r1, a_tx_start, a_tx_busy, a_abort, a_busy;
  logic [7:0] a_tx_data;
  logic [1:0] a_grant;
  logic       tb_busy, model_en;
  int unsigned a_cnt;

  // DUT B: GAP_BITS=0
  logic       bv0, bl0, bv1, bl1;
  logic [7:0] bd0, bd1;
  logic       b_r0, b_r1, b_tx_start, b_tx_busy, b_abort, b_busy;
  logic [7:0] b_tx_data;
  logic [1:0] b_grant;
  int unsigned b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(
    .CLKS_PER_BIT  (Cpb),
    .GAP_BITS      (2),
    .TIMEOUT_CYCLES(Tout)
  ) u_dut_a (
    .clk       (clk),
    .reset     (rst_n),
    .req0_valid(v0),
    .req0_data (d0),
    .req0_last (l0),
    .req0_ready(a_r0),
    .req1_valid(v1),
    .req1_data (d1),
    .req1_last (l1),
    .req1_ready(a_r1),
    .tx_start  (a_tx_start),
    .tx_data   (a_tx_data),
    .tx_busy   (a_tx_busy),
    .grant     (a_grant),
    .abort     (a_abort),
    .busy      (a_busy)
  );

  uart_tx_arbiter #(
    .CLKS_PER_BIT  (Cpb),
    .GAP_BITS      (0),
    .TIMEOUT_CYCLES(Tout)
  ) u_dut_b (
    .clk       (clk),
    .reset     (rst_n),
    .req0_valid(bv0),
    .req0_data (bd0),
    .req0_last (bl0),
    .req0_ready(b_r0),
    .req1_valid(bv1),
    .req1_data (bd1),
    .req1_last (bl1),
    .req1_ready(b_r1),
    .tx_start  (b_tx_start),
    .tx_data   (b_tx_data),
    .tx_busy   (b_tx_busy),
    .grant     (b_grant),
    .abort     (b_abort),
    .busy      (b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural transmitters: busy for one 10-bit frame after each start pulse.
  always @(posedge clk) begin
    if (!rst_n || !model_en) a_cnt <= 0;
    else if (a_tx_start)     a_cnt <= Busy;
    else if (a_cnt != 0)     a_cnt <= a_cnt - 1;
  end
  assign a_tx_busy = model_en ? (a_cnt != 0) : tb_busy;

  always @(posedge clk) begin
    if (!rst_n)          b_cnt <= 0;
    else if (b_tx_start) b_cnt <= Busy;
    else if (b_cnt != 0) b_cnt <= b_cnt - 1;
  end
  assign b_tx_busy = (b_cnt != 0);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1);
  end

  typedef struct {
    logic       rst, v0;
    logic [7:0] d0;
    logic       l0, v1;
    logic [7:0] d1;
    logic       l1, txb;
    logic [1:0] g;
    logic       r0, r1, st, bz;
    logic [7:0] txd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic iv0, input logic [7:0] id0, input logic il0,
                     input logic iv1, input logic [7:0] id1, input logic il1, input logic txb,
                     input logic [1:0] g, input logic r0, input logic r1, input logic st,
                     input logic bz, input logic [7:0] txd);
    vec_t v;
    v = '{rst, iv0, id0, il0, iv1, id1, il1, txb, g, r0, r1, st, bz, txd};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte on DUT A and check it reaches tx_start the cycle after acceptance.
  task automatic xfer_a(input int ch, input logic [7:0] d, input logic l);
    int n;
    n = 0;
    if (ch == 0) begin v0 = 1'b1; d0 = d; l0 = l; end
    else         begin v1 = 1'b1; d1 = d; l1 = l; end
    while (((ch == 0) ? a_r0 : a_r1) !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("xfer_ready_wait", 32'(n < 1000), 1);
    tick();
    chk("xfer_tx_start", a_tx_start, 1);
    chk("xfer_tx_data", a_tx_data, d);
    chk("xfer_grant", a_grant, (ch == 0) ? 2'b01 : 2'b10);
    if (ch == 0) v0 = 1'b0;
    else         v1 = 1'b0;
  endtask

  task automatic wait_a_idle();
    int n;
    n = 0;
    while (a_busy !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    chk("wait_a_idle", 32'(n < 1000), 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; v0 = 0; d0 = 0; l0 = 0; v1 = 0; d1 = 0; l1 = 0;
    tb_busy = 0; model_en = 0;
    bv0 = 0; bd0 = 0; bl0 = 0; bv1 = 0; bd1 = 0; bl1 = 0;

    // rst v0 d0 l0 | v1 d1 l1 | txb || grant r0 r1 start busy txd
    for (int i = 0; i < 3; i++)
      add(0, 1, 8'h55, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 0, 8'h00);
    add(1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 2'b01, 1, 0, 0, 1, 8'h00);
    add(1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 2'b01, 0, 0, 1, 1, 8'h55);
    add(1, 1, 8'h00, 1, 1, 8'hA1, 0, 0, 2'b01, 0, 0, 0, 1, 8'h55);
    add(1, 1, 8'h00, 1, 1, 8'hA1, 0, 0, 2'b01, 0, 0, 0, 1, 8'h55);
    add(1, 1, 8'h00, 1, 1, 8'hA1, 0, 1, 2'b01, 0, 0, 0, 1, 8'h55);
    add(1, 1, 8'h00, 1, 1, 8'hA1, 0, 1, 2'b01, 0, 0, 0, 1, 8'h55);
    add(1, 1, 8'h00, 1, 1, 8'hA1, 0, 0, 2'b01, 1, 0, 0, 1, 8'h55);
    add(1, 1, 8'h00, 1, 1, 8'hA1, 0, 0, 2'b01, 0, 0, 1, 1, 8'h00);
    add(1, 0, 8'h00, 0, 1, 8'hA1, 0, 1, 2'b01, 0, 0, 0, 1, 8'h00);
    add(1, 0, 8'h00, 0, 1, 8'hA1, 0, 1, 2'b01, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < GapA; i++)
      add(1, 1, 8'h77, 1, 1, 8'hA1, 0, 0, 2'b00, 0, 0, 0, 1, 8'h00);
    add(1, 1, 8'h77, 1, 1, 8'hA1, 0, 0, 2'b00, 0, 0, 0, 0, 8'h00);
    add(1, 1, 8'h77, 1, 1, 8'hA1, 0, 0, 2'b10, 0, 1, 0, 1, 8'h00);
    add(1, 1, 8'h77, 1, 1, 8'hA1, 0, 0, 2'b10, 0, 0, 1, 1, 8'hA1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst; v0 = vecs[i].v0; d0 = vecs[i].d0; l0 = vecs[i].l0;
      v1 = vecs[i].v1; d1 = vecs[i].d1; l1 = vecs[i].l1; tb_busy = vecs[i].txb;
      tick();
      chk($sformatf("vec%0d_grant", i), a_grant, vecs[i].g);
      chk($sformatf("vec%0d_ready0", i), a_r0, vecs[i].r0);
      chk($sformatf("vec%0d_ready1", i), a_r1, vecs[i].r1);
      chk($sformatf("vec%0d_tx_start", i), a_tx_start, vecs[i].st);
      chk($sformatf("vec%0d_busy", i), a_busy, vecs[i].bz);
      chk($sformatf("vec%0d_tx_data", i), a_tx_data, vecs[i].txd);
      chk($sformatf("vec%0d_abort", i), a_abort, 0);
    end

    // Finish req1's packet with the transmitter model driving tx_busy; req0 (0x77) waits.
    model_en = 1'b1;
    xfer_a(1, 8'hA2, 1'b1);
    n = 0;
    while (a_grant !== 2'b00 && n < 1000) begin tick(); n++; end
    chk("rr_pkt1_release", 32'(n < 1000), 1);
    n = 0;
    while (a_busy === 1'b1 && n < 100) begin tick(); n++; end
    chk("gap_len", n, GapA);
    tick();
    chk("rr_req0_after_req1", a_grant, 2'b01);
    xfer_a(0, 8'h77, 1'b1);
    wait_a_idle();

    // Timeout: req0 stalls mid-packet while req1 waits.
    xfer_a(0, 8'h11, 1'b0);
    v1 = 1'b1; d1 = 8'hB1; l1 = 1'b1;
    n = 0;
    while (a_r0 !== 1'b1 && n < 1000) begin
      chk("no_interleave_r1", a_r1, 0);
      tick();
      n++;
    end
    chk("tout_accept_wait", 32'(n < 1000), 1);
    n = 0;
    while (a_abort !== 1'b1 && n < 500) begin
      if (a_r0 === 1'b1) n++;
      tick();
    end
    chk("tout_ready_cycles", n, Tout);
    chk("tout_abort", a_abort, 1);
    chk("tout_grant", a_grant, 2'b00);
    chk("tout_busy", a_busy, 0);
    chk("tout_tx_data_held", a_tx_data, 8'h11);
    tick();
    chk("tout_abort_pulse", a_abort, 0);
    chk("tout_req1_grant", a_grant, 2'b10);
    chk("tout_req1_ready", a_r1, 1);
    xfer_a(1, 8'hB1, 1'b1);
    wait_a_idle();

    // DUT B, no gap: req1 granted the cycle after the last busy falls.
    bv0 = 1; bd0 = 8'hC3; bl0 = 1; bv1 = 1; bd1 = 8'hD4; bl1 = 1;
    tick();
    chk("b_first_grant", b_grant, 2'b01);
    chk("b_r1_blocked", b_r1, 0);
    tick();
    chk("b_tx_start", b_tx_start, 1);
    chk("b_tx_data", b_tx_data, 8'hC3);
    bv0 = 0;
    n = 0;
    while (b_tx_busy !== 1'b1 && n < 20) begin tick(); n++; end
    chk("b_busy_rise", 32'(n < 20), 1);
    n = 0;
    while (b_tx_busy === 1'b1 && n < 200) begin tick(); n++; end
    chk("b_busy_fall", 32'(n < 200), 1);
    chk("b_grant_held", b_grant, 2'b01);
    tick();
    chk("b_idle_grant", b_grant, 2'b00);
    chk("b_idle_busy", b_busy, 0);
    tick();
    chk("b_next_grant", b_grant, 2'b10);
    chk("b_next_ready", b_r1, 1);
    tick();
    chk("b_next_start", b_tx_start, 1);
    chk("b_next_data", b_tx_data, 8'hD4);
    chk("b_no_abort", b_abort, 0);
    bv1 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
